// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the nibble step index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        int unsigned steps;
        steps = width / NIBBLE;
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/carry_look_ahead_adder_cin_cout_4.sv
// 4-bit carry-look-ahead adder with carry in and carry out.
module carry_look_ahead_adder_cin_cout_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and fully expanded look-ahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared 4-bit CLA,
// one nibble per clock, LSB nibble first.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / NIBBLE;
    localparam int unsigned IW = idx_width(WIDTH);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             last_step;

    // Nibble select for the current step; b_q already holds B or ~B.
    always_comb begin
        a_nib     = a_q[int'(idx_q) * NIBBLE +: NIBBLE];
        b_nib     = b_q[int'(idx_q) * NIBBLE +: NIBBLE];
        last_step = (idx_q == IW'(N - 1));
    end

    carry_look_ahead_adder_cin_cout_4 u_cla (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state, operand latch, nibble write-back and registered status decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q) * NIBBLE +: NIBBLE] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + IW'(1);
                if (last_step) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t        sb[$];

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arithmetic on full-width integers.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb_mode);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] beff;
        beff = sb_mode ? ~bv : bv;
        full = {1'b0, av} + {1'b0, beff} + {{W{1'b0}}, (sb_mode ? 1'b1 : ci)};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (av[W-1] == beff[W-1]) && (full[W-1] != av[W-1]);
        return e;
    endfunction

    // Pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check_eq("done_expected", 32'(sb.size() != 0), 32'd1);
            check_eq("busy_with_done", 32'(busy), 32'd0);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sum", 32'(sum), 32'(e.s));
                check_eq("cout", 32'(cout), 32'(e.c));
                check_eq("overflow", 32'(overflow), 32'(e.v));
            end
        end
    end

    // Issue one operation and verify busy/done timing.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sb_mode);
        int unsigned lat = 0;
        int unsigned nbusy = 0;
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb_mode; start = 1'b1;
        sb.push_back(model(av, bv, ci, sb_mode));
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) nbusy++;
        end
        check_eq("latency", lat, N + 1);
        check_eq("busy_cycles", nbusy, N);
        @(negedge clk);
        check_eq("done_pulse_single", 32'(done), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned lat;
        exp_t        dummy;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // start held through RUN with changing operands, then re-accepted in DONE
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; start = 1'b1;
        sb.push_back(model(16'h0102, 16'h0304, 1'b0, 1'b0));
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        end
        @(negedge clk);
        check_eq("hold_done_cycle", 32'(done), 32'd1);
        a = 16'hA5A5; b = 16'h1111; cin = 1'b0; sub = 1'b1;
        sb.push_back(model(16'hA5A5, 16'h1111, 1'b0, 1'b1));
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) check_eq("b2b_busy", 32'(busy), 32'd1);
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq("b2b_latency", lat, N + 1);
        repeat (2) @(negedge clk);

        // reset during RUN cycle 2
        a = 16'h3333; b = 16'h4444; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_done", 32'(done), 32'd0);
        check_eq("async_sum", 32'(sum), 32'd0);
        check_eq("async_cout", 32'(cout), 32'd0);
        check_eq("async_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("no_done_after_reset", 32'(done | busy), 32'd0);
        end

        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        dummy = '0;
        check_eq("scoreboard_drained", sb.size(), 32'd0);
        if (dummy.c) $display("unreachable");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle add/subtract sequencer that time-shares one instance of the team's 4-bit carry-look-ahead adder (`carry_look_ahead_adder_cin_cout_4`) to produce a WIDTH-bit result, one nibble per clock, LSB nibble first. It latches operands on a start handshake and chains carry between nibbles through a carry register. It reports busy/done, carry-out and signed overflow. It sits in the CPU datapath wherever a wide add is needed but area matters more than latency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when state is IDLE or DONE
- sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, initial carry forced to 1, cin ignored); latched with start
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- cin  input  1  carry-in for add mode, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  result register
- cout  output  1  final carry out; in sub mode 1 = no borrow
- overflow  output  1  signed two's-complement overflow of the full-width operation

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, step index=0, carry register=0, latched operands=0.
- IDLE/DONE with start=1: latch a, b_eff (b or ~b), sub; carry register ← sub ? 1 : cin; index ← 0; next state RUN.
- IDLE with start=0: stay. DONE with start=0: → IDLE.
- RUN, each cycle: adder inputs are A/B_eff nibble[index] and the carry register. On the edge, sum nibble[index] ← R and carry register ← adder cout. index increments.
  - When index = N−1: cout ← adder cout, overflow ← (A_msb == B_eff_msb) && (R[3] != A_msb), next state DONE.
- start during RUN is ignored; the operation is not restarted or queued.
- sum is written nibble-by-nibble during RUN, so intermediate values are visible. It is valid only in the DONE cycle and thereafter until the next accepted start. cout and overflow hold likewise.
- Back-to-back: start asserted in the DONE cycle is accepted; no idle cycle is required.
- rst_n low at any time, including mid-RUN: immediate return to reset values. The partial result is discarded.

## Timing
- start sampled high at edge k → busy high cycles k+1…k+N → done high in cycle k+N+1 only.
- Throughput: one operation per N+1 cycles with back-to-back start.
- Adder path is combinational within one cycle: nibble mux → CLA → sum/carry registers.
- done and busy are registered state decodes, never simultaneously high.

## Structure
- Shared package: state enumeration (IDLE, RUN, DONE), NIBBLE=4 constant, index width function clog2(WIDTH/4) (minimum 1 bit).
- One sub-module instance: `carry_look_ahead_adder_cin_cout_4`, unmodified. Nibble select mux and sum write-enable decode stay in the controller.
- Elaboration-time check that WIDTH%4==0.

## Test plan
- Reset then add: a=0x1234, b=0x4321, cin=0, sub=0 → busy cycles 1–4, done in cycle 5, sum=0x5555, cout=0, overflow=0.
- Full carry ripple: 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Also 0xFFFF+0x0000 with cin=1 → sum=0x0000, cout=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, overflow=0. a=0x8000−0x0001 → sum=0x7FFF, cout=1, overflow=1.
- Signed overflow on add: 0x7FFF+0x0001 → sum=0x8000, cout=0, overflow=1.
- Handshake: start held high through RUN with changing a/b → result reflects only the first latched operands. start in DONE cycle → new busy next cycle, done 5 cycles later.
- Reset mid-op: assert rst_n=0 during RUN cycle 2 → all outputs 0 asynchronously. After release, no done pulse until a new start.
